// File: rtl/clk_health_monitor.sv
// Clock health monitor: classifies 1 s frequency samples against a window,
// tracks lock/loss/stop state, and keeps sticky alarm and min/max/last statistics.
module clk_health_monitor #(
  parameter logic [31:0] F_MIN  = 32'd99_900_000,
  parameter logic [31:0] F_MAX  = 32'd100_100_000,
  parameter int unsigned N_GOOD = 3,
  parameter int unsigned N_BAD  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] freq,
  input  logic        freq_valid,
  input  logic        clear_stats,
  output logic [1:0]  state,
  output logic        clk_ok,
  output logic        alarm_sticky,
  output logic [15:0] err_count,
  output logic [31:0] last_freq,
  output logic [31:0] freq_min,
  output logic [31:0] freq_max
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_LOST    = 2'd2,
    ST_STOPPED = 2'd3
  } state_t;

  localparam logic [8:0] LP_N_GOOD = 9'(N_GOOD);
  localparam logic [8:0] LP_N_BAD  = 9'(N_BAD);

  state_t      r_state;
  logic [7:0]  r_good_cnt;
  logic [7:0]  r_bad_cnt;
  logic        r_clk_ok;
  logic        r_alarm;
  logic [15:0] r_err_count;
  logic [31:0] r_last;
  logic [31:0] r_min;
  logic [31:0] r_max;

  state_t      w_state_nxt;
  state_t      w_eval_state;
  logic [7:0]  w_good_nxt;
  logic [7:0]  w_bad_nxt;
  logic        w_entry;
  logic        w_zero;
  logic        w_in_win;
  logic [8:0]  w_good_inc;
  logic [8:0]  w_bad_inc;

  logic        w_alarm_base;
  logic [15:0] w_err_base;
  logic [31:0] w_min_base;
  logic [31:0] w_max_base;
  logic        w_alarm_nxt;
  logic [15:0] w_err_nxt;
  logic [31:0] w_last_nxt;
  logic [31:0] w_min_nxt;
  logic [31:0] w_max_nxt;

  assign w_zero     = (freq == '0);
  assign w_in_win   = (freq >= F_MIN) && (freq <= F_MAX);
  assign w_good_inc = {1'b0, r_good_cnt} + 9'd1;
  assign w_bad_inc  = {1'b0, r_bad_cnt} + 9'd1;
  // A non-zero sample in STOPPED is judged as if already in ACQUIRE.
  assign w_eval_state = (r_state == ST_STOPPED) ? ST_ACQUIRE : r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_ACQUIRE;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_clk_ok   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
      r_clk_ok   <= (w_state_nxt == ST_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_entry     = 1'b0;
    if (freq_valid) begin
      if (w_zero) begin
        w_state_nxt = ST_STOPPED;
        w_good_nxt  = '0;
        w_bad_nxt   = '0;
        w_entry     = (r_state != ST_STOPPED);
      end else begin
        case (w_eval_state)
          ST_LOCKED: begin
            if (w_in_win) begin
              w_bad_nxt = '0;
            end else if (w_bad_inc == LP_N_BAD) begin
              w_state_nxt = ST_LOST;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
              w_entry     = 1'b1;
            end else begin
              w_bad_nxt = w_bad_inc[7:0];
            end
          end
          default: begin
            w_state_nxt = w_eval_state;
            if (!w_in_win) begin
              w_good_nxt = '0;
            end else if (w_good_inc == LP_N_GOOD) begin
              w_state_nxt = ST_LOCKED;
              w_good_nxt  = '0;
              w_bad_nxt   = '0;
            end else begin
              w_good_nxt = w_good_inc[7:0];
            end
          end
        endcase
      end
    end
  end

  // Clear takes effect first; a same-cycle sample then updates the cleared values.
  always_comb begin
    w_alarm_base = clear_stats ? 1'b0 : r_alarm;
    w_err_base   = clear_stats ? '0   : r_err_count;
    w_min_base   = clear_stats ? '1   : r_min;
    w_max_base   = clear_stats ? '0   : r_max;
    w_alarm_nxt  = w_alarm_base;
    w_err_nxt    = w_err_base;
    w_last_nxt   = r_last;
    w_min_nxt    = w_min_base;
    w_max_nxt    = w_max_base;
    if (freq_valid) begin
      w_last_nxt = freq;
      if (freq < w_min_base) w_min_nxt = freq;
      if (freq > w_max_base) w_max_nxt = freq;
      if (w_entry) begin
        w_alarm_nxt = 1'b1;
        if (w_err_base != '1) w_err_nxt = w_err_base + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarm     <= 1'b0;
      r_err_count <= '0;
      r_last      <= '0;
      r_min       <= '1;
      r_max       <= '0;
    end else begin
      r_alarm     <= w_alarm_nxt;
      r_err_count <= w_err_nxt;
      r_last      <= w_last_nxt;
      r_min       <= w_min_nxt;
      r_max       <= w_max_nxt;
    end
  end

  assign state        = r_state;
  assign clk_ok       = r_clk_ok;
  assign alarm_sticky = r_alarm;
  assign err_count    = r_err_count;
  assign last_freq    = r_last;
  assign freq_min     = r_min;
  assign freq_max     = r_max;

endmodule

// File: tb/tb_clk_health_monitor.sv
// Directed bench for clk_health_monitor with a sample-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_clk_health_monitor;

  localparam logic [31:0] P_FMIN = 32'd99;
  localparam logic [31:0] P_FMAX = 32'd101;
  localparam int P_NG = 3;
  localparam int P_NB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] freq;
  logic        freq_valid;
  logic        clear_stats;
  logic [1:0]  state;
  logic        clk_ok;
  logic        alarm_sticky;
  logic [15:0] err_count;
  logic [31:0] last_freq;
  logic [31:0] freq_min;
  logic [31:0] freq_max;

  clk_health_monitor #(
    .F_MIN (P_FMIN),
    .F_MAX (P_FMAX),
    .N_GOOD(P_NG),
    .N_BAD (P_NB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .freq        (freq),
    .freq_valid  (freq_valid),
    .clear_stats (clear_stats),
    .state       (state),
    .clk_ok      (clk_ok),
    .alarm_sticky(alarm_sticky),
    .err_count   (err_count),
    .last_freq   (last_freq),
    .freq_min    (freq_min),
    .freq_max    (freq_max)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Reference model: state as 0..3, run lengths of good/bad samples.
  int          m_state;
  int          m_good_run;
  int          m_bad_run;
  bit          m_alarm;
  int          m_err;
  logic [31:0] m_last;
  logic [31:0] m_min;
  logic [31:0] m_max;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_good_run = 0; m_bad_run = 0;
    m_alarm = 1'b0; m_err = 0;
    m_last = 32'd0; m_min = 32'hFFFF_FFFF; m_max = 32'd0;
  endtask

  task automatic model_loss();
    m_alarm = 1'b1;
    if (m_err < 65535) m_err++;
  endtask

  task automatic model_apply(input bit v, input logic [31:0] f, input bit c);
    bit inw;
    if (c) begin
      m_min = 32'hFFFF_FFFF; m_max = 32'd0; m_err = 0; m_alarm = 1'b0;
    end
    if (v) begin
      m_last = f;
      if (f < m_min) m_min = f;
      if (f > m_max) m_max = f;
      inw = (f >= P_FMIN) && (f <= P_FMAX);
      if (f == 32'd0) begin
        if (m_state != 3) model_loss();
        m_state = 3; m_good_run = 0; m_bad_run = 0;
      end else begin
        if (m_state == 3) m_state = 0;
        if (m_state == 1) begin
          if (inw) m_bad_run = 0;
          else begin
            m_bad_run++;
            if (m_bad_run >= P_NB) begin
              m_state = 2; m_good_run = 0; m_bad_run = 0;
              model_loss();
            end
          end
        end else begin
          if (!inw) m_good_run = 0;
          else begin
            m_good_run++;
            if (m_good_run >= P_NG) begin
              m_state = 1; m_good_run = 0; m_bad_run = 0;
            end
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state",        {30'd0, state},        m_state[31:0]);
      chk("clk_ok",       {31'd0, clk_ok},       (m_state == 1) ? 32'd1 : 32'd0);
      chk("alarm_sticky", {31'd0, alarm_sticky}, {31'd0, m_alarm});
      chk("err_count",    {16'd0, err_count},    m_err[31:0]);
      chk("last_freq",    last_freq,             m_last);
      chk("freq_min",     freq_min,              m_min);
      chk("freq_max",     freq_max,              m_max);
    end
  end

  // Drives one cycle of inputs; returns at negedge+1 with the cycle's result visible.
  task automatic step(input bit v, input logic [31:0] f, input bit c);
    freq_valid  = v;
    freq        = f;
    clear_stats = c;
    @(posedge clk);
    model_apply(v, f, c);
    @(negedge clk);
    #1;
    freq_valid  = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic smp(input logic [31:0] f);
    step(1'b1, f, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, {30'd0, state}, 32'd0);
    chk({tag, "_clk_ok"}, {31'd0, clk_ok}, 32'd0);
    chk({tag, "_alarm"}, {31'd0, alarm_sticky}, 32'd0);
    chk({tag, "_err"}, {16'd0, err_count}, 32'd0);
    chk({tag, "_last"}, last_freq, 32'd0);
    chk({tag, "_min"}, freq_min, 32'hFFFF_FFFF);
    chk({tag, "_max"}, freq_max, 32'd0);
  endtask

  initial begin
    reset = 1'b1; freq = '0; freq_valid = 1'b0; clear_stats = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;
    chk_on = 1'b1;

    // Lock acquisition: not before the third strobe
    smp(32'd100); smp(32'd100);
    chk("lock_early", {30'd0, state}, 32'd0);
    smp(32'd100);
    chk("lock_state", {30'd0, state}, 32'd1);
    chk("lock_ok", {31'd0, clk_ok}, 32'd1);
    chk("lock_alarm", {31'd0, alarm_sticky}, 32'd0);

    // Loss after two consecutive out-of-window samples
    smp(32'd102); smp(32'd100);
    chk("hold_locked", {30'd0, state}, 32'd1);
    smp(32'd98);
    chk("one_bad", {30'd0, state}, 32'd1);
    smp(32'd98);
    chk("lost_state", {30'd0, state}, 32'd2);
    chk("lost_alarm", {31'd0, alarm_sticky}, 32'd1);
    chk("lost_err", {16'd0, err_count}, 32'd1);
    chk("lost_ok", {31'd0, clk_ok}, 32'd0);

    step(1'b0, 32'd0, 1'b0); step(1'b0, 32'd7, 1'b0);

    // Relock from LOST interrupted by an out-of-window sample
    smp(32'd100); smp(32'd100); smp(32'd150); smp(32'd100); smp(32'd100);
    chk("relock_early", {30'd0, state}, 32'd2);
    smp(32'd100);
    chk("relock_state", {30'd0, state}, 32'd1);
    chk("relock_min", freq_min, 32'd98);
    chk("relock_max", freq_max, 32'd150);

    // Stop: repeated zero counts once
    smp(32'd0);
    chk("stop_state", {30'd0, state}, 32'd3);
    chk("stop_err", {16'd0, err_count}, 32'd2);
    smp(32'd0);
    chk("stop_err_once", {16'd0, err_count}, 32'd2);
    smp(32'd100);
    chk("restart_state", {30'd0, state}, 32'd0);
    smp(32'd100); smp(32'd100);
    chk("restart_lock", {30'd0, state}, 32'd1);

    // Clear combined with zero sample
    step(1'b1, 32'd0, 1'b1);
    chk("clr0_min", freq_min, 32'd0);
    chk("clr0_max", freq_max, 32'd0);
    chk("clr0_alarm", {31'd0, alarm_sticky}, 32'd1);
    chk("clr0_err", {16'd0, err_count}, 32'd1);
    step(1'b0, 32'd0, 1'b1);
    chk("clr_err", {16'd0, err_count}, 32'd0);
    chk("clr_state", {30'd0, state}, 32'd3);
    chk("clr_min", freq_min, 32'hFFFF_FFFF);
    step(1'b1, 32'd0, 1'b1);
    chk("clr0_stopped_err", {16'd0, err_count}, 32'd0);

    // Out-of-window in STOPPED and ACQUIRE
    smp(32'd200);
    chk("stop_oow", {30'd0, state}, 32'd0);
    smp(32'd100); smp(32'd120); smp(32'd100); smp(32'd100);
    chk("acq_oow", {30'd0, state}, 32'd0);
    smp(32'd100);
    chk("acq_lock", {30'd0, state}, 32'd1);

    // Saturation
    #1;
    force dut.r_err_count = 16'hFFFF;
    m_err = 65535;
    #1;
    release dut.r_err_count;
    smp(32'd0);
    chk("sat_err", {16'd0, err_count}, 32'h0000_FFFF);
    chk("sat_alarm", {31'd0, alarm_sticky}, 32'd1);

    // Reset between second and third good sample
    smp(32'd100); smp(32'd100);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_vals("mid");
    @(negedge clk);
    #2;
    reset = 1'b0;
    smp(32'd100); smp(32'd100);
    chk("post_rst_early", {30'd0, state}, 32'd0);
    smp(32'd100);
    chk("post_rst_lock", {30'd0, state}, 32'd1);

    step(1'b0, 32'd0, 1'b0);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
